// File: rtl/median_pkg.sv
// Shared definitions for the median filter scan sequencer: FSM encoding,
// window geometry and 3x3 tap offset helpers.
package median_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DRAIN   = 3'd2,
      S_COMPUTE = 3'd3,
      S_WRITE   = 3'd4,
      S_ADVANCE = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam int         WIN_SIZE   = 9;
   localparam logic [3:0] TAP_LAST   = 4'd8;
   localparam logic [3:0] TAP_CENTRE = 4'd4;

   // Tap k walks the window row-major; offsets are in {-1, 0, +1}.
   function automatic int tap_dr(input logic [3:0] k);
      return int'(k) / 3 - 1;
   endfunction

   function automatic int tap_dc(input logic [3:0] k);
      return int'(k) % 3 - 1;
   endfunction

endpackage

// File: rtl/median_addr_gen.sv
// Combinational neighbour address: clamps (row+dr, col+dc) to the image so
// edges replicate, then forms row*WIDTH+col.
module median_addr_gen
   import median_pkg::*;
#(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 512,
   parameter int AW     = 18
) (
   input  logic [9:0]    row,
   input  logic [9:0]    col,
   input  logic [3:0]    k,
   output logic [AW-1:0] addr
);

   int r_c;
   int c_c;

   always_comb begin
      r_c = int'(row) + tap_dr(k);
      c_c = int'(col) + tap_dc(k);
      if (r_c < 0)
         r_c = 0;
      else if (r_c > HEIGHT - 1)
         r_c = HEIGHT - 1;
      if (c_c < 0)
         c_c = 0;
      else if (c_c > WIDTH - 1)
         c_c = WIDTH - 1;
      addr = AW'(r_c * WIDTH + c_c);
   end

endmodule

// File: rtl/median_scan_ctrl.sv
// Raster-scan sequencer: fetches each 3x3 window, hands it to the median core
// and writes the result back. States:
//   IDLE    | waiting for start
//   FETCH   | one read per cycle, taps k=0..8
//   DRAIN   | last read data lands in D8
//   COMPUTE | median core busy, window frozen
//   WRITE   | one output memory write
//   ADVANCE | step to next centre pixel or finish
//   DONE    | frame complete, done held until next start
module median_scan_ctrl
   import median_pkg::*;
#(
   parameter int WIDTH  = 512,
   parameter int HEIGHT = 512,
   parameter int AW     = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   input  logic [7:0]    rd_data_i,
   output logic [7:0]    D0,
   output logic [7:0]    D1,
   output logic [7:0]    D2,
   output logic [7:0]    D3,
   output logic [7:0]    D4,
   output logic [7:0]    D5,
   output logic [7:0]    D6,
   output logic [7:0]    D7,
   output logic [7:0]    D8,
   output logic          med_start_o,
   input  logic          med_done_i,
   input  logic [7:0]    med_pix_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   output logic [2:0]    State,
   output logic [9:0]    Row_o,
   output logic [9:0]    Col_o,
   output logic          done
);

   localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);
   localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);

   state_t        state_q, state_d;
   logic [3:0]    k_q, k_d;
   logic [9:0]    row_q, row_d, col_q, col_d;
   logic [AW-1:0] rd_addr_d, out_addr;
   logic          pend_q;
   logic [3:0]    pend_k_q;
   logic [7:0]    win_q [WIN_SIZE];

   // Read address is formed from next-state coordinates so the strobe and
   // address can be registered together with the state transition.
   median_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) u_rd_addr (
      .row  (row_d),
      .col  (col_d),
      .k    (k_d),
      .addr (rd_addr_d)
   );

   median_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) u_wr_addr (
      .row  (row_q),
      .col  (col_q),
      .k    (TAP_CENTRE),
      .addr (out_addr)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH;
               k_d     = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_FETCH: begin
            if (k_q == TAP_LAST)
               state_d = S_DRAIN;
            else
               k_d = k_q + 4'd1;
         end
         S_DRAIN:   state_d = S_COMPUTE;
         // The start cycle is skipped so a stale result cannot be taken.
         S_COMPUTE: if (!med_start_o && med_done_i) state_d = S_WRITE;
         S_WRITE:   state_d = S_ADVANCE;
         S_ADVANCE: begin
            k_d     = '0;
            state_d = S_FETCH;
            if (col_q < COL_LAST) begin
               col_d = col_q + 10'd1;
            end else begin
               col_d = '0;
               if (row_q < ROW_LAST)
                  row_d = row_q + 10'd1;
               else
                  state_d = S_DONE;
            end
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         rd_en_o     <= 1'b0;
         rd_addr_o   <= '0;
         pend_q      <= 1'b0;
         pend_k_q    <= '0;
         for (int i = 0; i < WIN_SIZE; i++) win_q[i] <= '0;
         med_start_o <= 1'b0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         wr_data_o   <= '0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         row_q       <= row_d;
         col_q       <= col_d;
         rd_en_o     <= (state_d == S_FETCH);
         if (state_d == S_FETCH)
            rd_addr_o <= rd_addr_d;
         pend_q      <= rd_en_o;
         pend_k_q    <= k_q;
         if (pend_q)
            win_q[pend_k_q] <= rd_data_i;
         med_start_o <= (state_q == S_DRAIN);
         wr_en_o     <= (state_d == S_WRITE);
         if (state_q == S_COMPUTE && state_d == S_WRITE) begin
            wr_data_o <= med_pix_i;
            wr_addr_o <= out_addr;
         end
         done        <= (state_d == S_DONE);
      end
   end

   assign State = state_q;
   assign Row_o = row_q;
   assign Col_o = col_q;
   assign D0    = win_q[0];
   assign D1    = win_q[1];
   assign D2    = win_q[2];
   assign D3    = win_q[3];
   assign D4    = win_q[4];
   assign D5    = win_q[5];
   assign D6    = win_q[6];
   assign D7    = win_q[7];
   assign D8    = win_q[8];

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Scoreboard bench for median_scan_ctrl on a 4x4 image: a reference model
// predicts every window and median write; a negedge monitor checks them.
module tb_median_scan_ctrl;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int AW   = 4;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [7:0]    rd_data_i = '0;
   logic [7:0]    D0, D1, D2, D3, D4, D5, D6, D7, D8;
   logic          med_start_o;
   logic          med_done_i = 1'b0;
   logic [7:0]    med_pix_i = '0;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [7:0]    wr_data_o;
   logic [2:0]    State;
   logic [9:0]    Row_o, Col_o;
   logic          done;

   median_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
      .med_start_o(med_start_o), .med_done_i(med_done_i), .med_pix_i(med_pix_i),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .State(State), .Row_o(Row_o), .Col_o(Col_o), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic [7:0]  mem [NPIX];
   wr_t         exp_wr[$];
   logic [71:0] exp_win[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_wr_cyc = -1;
   int          lat = 1;
   bit          spur_en = 1'b0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic logic [7:0] med9(input logic [71:0] w);
      int v[9];
      int t;
      for (int i = 0; i < 9; i++) v[i] = int'(w[8*i +: 8]);
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      return 8'(v[4]);
   endfunction

   function automatic logic [71:0] model_win(input int r, input int c);
      logic [71:0] w;
      int rr, cc;
      w = '0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            rr = (r + dr < 0) ? 0 : ((r + dr > H - 1) ? H - 1 : r + dr);
            cc = (c + dc < 0) ? 0 : ((c + dc > W - 1) ? W - 1 : c + dc);
            w = {w[63:0], mem[rr*W + cc]};
         end
      return w;
   endfunction

   task automatic push_frame();
      wr_t         e;
      logic [71:0] w;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            w = model_win(r, c);
            exp_win.push_back(w);
            e.addr = AW'(r*W + c);
            e.data = med9(w);
            exp_wr.push_back(e);
         end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];

   // Median core stand-in: result L cycles after med_start_o, optional
   // stray med_done_i pulses whenever no result is pending.
   int         mcnt = 0;
   logic [7:0] mpix = '0;
   always @(posedge clk) begin
      if (rst) begin
         mcnt = 0;
         med_done_i <= 1'b0;
      end else begin
         if (med_start_o) begin
            mcnt = lat;
            mpix = med9({D0, D1, D2, D3, D4, D5, D6, D7, D8});
         end
         if (mcnt == 1) begin
            med_done_i <= 1'b1;
            med_pix_i  <= mpix;
         end else if (mcnt == 0 && spur_en && $urandom_range(0, 3) == 0) begin
            med_done_i <= 1'b1;
            med_pix_i  <= 8'($urandom);
         end else begin
            med_done_i <= 1'b0;
         end
         if (mcnt > 0) mcnt--;
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (med_start_o) begin
         if (exp_win.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL win_unexpected: got window %0h expected none", {D0, D1, D2, D3, D4, D5, D6, D7, D8});
         end else
            check("window", {D0, D1, D2, D3, D4, D5, D6, D7, D8}, exp_win.pop_front());
      end
      if (wr_en_o) begin
         if (exp_wr.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wr_unexpected: got write addr %0d data %0h expected none", wr_addr_o, wr_data_o);
         end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 72'(wr_addr_o), 72'(e.addr));
            check("wr_data", 72'(wr_data_o), 72'(e.data));
            if (last_wr_cyc >= 0)
               check("wr_spacing", 72'(cyc - last_wr_cyc), 72'(13 + lat));
            last_wr_cyc = cyc;
         end
      end
   end

   task automatic load_mem(input bit rnd);
      for (int i = 0; i < NPIX; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int l, input bit rnd, input bit spur, input bit glitch);
      int n;
      bit seen;
      lat = l;
      spur_en = spur;
      load_mem(rnd);
      push_frame();
      last_wr_cyc = -1;
      pulse_start();
      check("first_rd_en", 72'(rd_en_o), 72'(1));
      check("first_rd_addr", 72'(rd_addr_o), 72'(0));
      check("done_cleared", 72'(done), 72'(0));
      check("state_fetch", 72'(State), 72'(1));
      n = 0;
      seen = 1'b0;
      while (n < 3000 && !seen) begin
         if (glitch && n == 6*(13 + l) + 3) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
         if (done) seen = 1'b1;
      end
      check("done_timing", 72'(n), 72'(NPIX*(13 + l)));
      check("wr_left", 72'(exp_wr.size()), 72'(0));
      check("win_left", 72'(exp_win.size()), 72'(0));
      repeat (5) @(posedge clk);
      #1;
      check("done_held", 72'(done), 72'(1));
      check("state_done", 72'(State), 72'(6));
      exp_wr.delete();
      exp_win.delete();
   endtask

   task automatic run_abort();
      int n;
      bit active;
      lat = 1;
      spur_en = 1'b0;
      load_mem(1'b1);
      push_frame();
      last_wr_cyc = -1;
      pulse_start();
      n = 0;
      while (n < 3000 && !(State == 3'd3 && Row_o == 10'd2 && Col_o == 10'd1)) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort_reach", 72'(State == 3'd3 && Row_o == 10'd2 && Col_o == 10'd1), 72'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_state", 72'(State), 72'(0));
      check("rst_outs", 72'({rd_en_o, med_start_o, wr_en_o, done, rd_addr_o, wr_addr_o,
                              wr_data_o, Row_o, Col_o}), 72'(0));
      check("rst_window", {D0, D1, D2, D3, D4, D5, D6, D7, D8}, 72'(0));
      check("abort_wr_left", 72'(exp_wr.size()), 72'(NPIX - 9));
      check("abort_win_left", 72'(exp_win.size()), 72'(NPIX - 10));
      exp_wr.delete();
      exp_win.delete();
      active = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (rd_en_o || wr_en_o || State != 3'd0) active = 1'b1;
      end
      check("idle_after_rst", 72'(active), 72'(0));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", 72'(State), 72'(0));
      check("reset_outs", 72'({rd_en_o, med_start_o, wr_en_o, done, rd_addr_o, wr_addr_o,
                                wr_data_o, Row_o, Col_o}), 72'(0));
      check("reset_window", {D0, D1, D2, D3, D4, D5, D6, D7, D8}, 72'(0));

      run_frame(1, 1'b0, 1'b0, 1'b0);
      run_frame(1, 1'b0, 1'b0, 1'b0);
      run_frame(5, 1'b1, 1'b1, 1'b0);
      run_frame(1, 1'b0, 1'b0, 1'b1);
      run_abort();
      run_frame(3, 1'b1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/median_scan_ctrl.md
# median_scan_ctrl

Sequencer for the salt-and-pepper median filter. It scans a WIDTH×HEIGHT 8-bit image in raster order and fetches each 3×3 neighbourhood from pixel memory into the D0..D8 window registers. It then hands the window to the median datapath and writes the returned median to output memory. It sits between the image RAMs and the median core inside `top`, and drives the State/Row_o/Col_o/done observation ports.

## Interface
- WIDTH, 512: image width in pixels (≤1023)
- HEIGHT, 512: image height in pixels (≤1023)
- AW, 18: pixel memory address width; must hold WIDTH*HEIGHT-1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  one-cycle pulse; begins a frame scan
- rd_en_o  out  1  pixel memory read strobe
- rd_addr_o  out  AW  read address = row*WIDTH+col
- rd_data_i  in  8  read data, valid exactly 1 cycle after rd_en_o
- D0..D8  out  8 each  window, row-major from (r-1,c-1) to (r+1,c+1)
- med_start_o  out  1  one-cycle pulse, window stable
- med_done_i  in  1  median result valid
- med_pix_i  in  8  median result
- wr_en_o  out  1  output memory write strobe
- wr_addr_o  out  AW  write address = Row_o*WIDTH+Col_o
- wr_data_o  out  8  pixel written
- State  out  3  current FSM state
- Row_o, Col_o  out  10 each  centre pixel coordinates
- done  out  1  frame complete, held high

## Operation
- States: IDLE=0, FETCH=1, DRAIN=2, COMPUTE=3, WRITE=4, ADVANCE=5, DONE=6. Values 7 and any illegal value go to IDLE.
- IDLE: on start, go to FETCH. Row_o=Col_o=0, tap counter k=0.
- FETCH: issue one read per cycle for k=0..8. Tap k uses dr=k/3-1 and dc=k%3-1.
  - Neighbour row and col are clamped to [0,HEIGHT-1] and [0,WIDTH-1]; edges replicate.
  - The word returned one cycle after tap k is loaded into D[k].
  - After k=8, go to DRAIN.
- DRAIN: capture D8, rd_en_o=0, go to COMPUTE.
- COMPUTE: med_start_o=1 on the first cycle only. D0..D8 are frozen throughout. med_done_i is sampled only on cycles where med_start_o=0. On med_done_i, latch med_pix_i into wr_data_o and go to WRITE.
- WRITE: wr_en_o=1 for one cycle at the current Row_o/Col_o, then ADVANCE.
- ADVANCE: if Col_o<WIDTH-1, increment Col_o. Otherwise set Col_o=0; if Row_o<HEIGHT-1, increment Row_o, else go to DONE. Otherwise go to FETCH with k=0.
- DONE: done=1 and held until the next start. start clears done and restarts the scan from (0,0).
- start in any state other than IDLE or DONE is ignored.
- med_done_i outside COMPUTE is ignored.
- Address arithmetic is unsigned AW-bit row*WIDTH+col. Clamp is applied before the multiply, so no out-of-range address is ever issued.

## Timing
- Reset values: State=IDLE, all strobes 0, D0..D8=0, Row_o=Col_o=0, addresses 0, wr_data_o=0, done=0.
- rst mid-frame aborts with no further reads or writes. The next frame needs a new start.
- First rd_en_o occurs in the cycle after start is sampled.
- Per-pixel cycles = 9 (FETCH) + 1 (DRAIN) + 1 + L (COMPUTE) + 1 (WRITE) + 1 (ADVANCE) = 13+L, where L≥1 is the median latency after med_start_o.
- Frame = WIDTH*HEIGHT*(13+L) cycles from the start sample to done rising.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package median_pkg holds:
  - state localparams (3-bit)
  - window size constant 9
  - tap offset helpers (dr/dc from k)
- Sub-module median_addr_gen (combinational): row, col, k -> clamped AW-bit address. It is reused by the output address path with k=4.

## Test plan
- WIDTH=HEIGHT=4, L=1, memory[i]=i, single start:
  - centre (0,0) read addresses 0,0,1,0,0,1,4,4,5 -> D0..D8 = 0,0,1,0,0,1,4,4,5
  - centre (3,3) reads 10,11,11,14,15,15,14,15,15
- Same setup, bench median model -> 16 writes to wr_addr 0..15 in order, 14 cycles apart. done rises 224 cycles after start and stays high.
- L=5 with med_done_i pulsed outside COMPUTE -> no spurious write. Spacing is 18 cycles.
- start pulsed during FETCH of pixel (1,2) -> ignored; scan and write sequence unchanged.
- rst asserted during COMPUTE of pixel (2,1) -> next cycle State=0, all outputs zero, no wr_en_o. A new start restarts at (0,0).
- After done, a second start -> done clears next cycle and the full 16-write frame repeats identically.
